operand_entry: RTL
==================

# operand_entry

Key-entry sequencer that sits between the keypad decoder and the calculator ALU. It turns a stream of decoded key codes into two decimal operands and an operator, then hands the triple to the ALU over a valid/ready handshake. It also drives the value currently being typed to the display path and flags illegal key sequences.

## Interface
- WIDTH, 16: operand width in bits; must satisfy 10^MAX_DIGITS − 1 < 2^WIDTH
- MAX_DIGITS, 4: maximum decimal digits per operand
- clk  in  1  system clock, single clock domain
- reset  in  1  synchronous, active-high reset
- key_valid  in  1  decoded key present this cycle
- key_code  in  4  0–9 digit, 10 ADD, 11 SUB, 12 MUL, 13 DIV, 14 EQUALS, 15 CLEAR
- key_ready  out  1  block accepts keys; key taken on clk edge when key_valid && key_ready
- operand_a  out  WIDTH  first operand, binary
- operand_b  out  WIDTH  second operand, binary
- op  out  2  00 add, 01 sub, 10 mul, 11 div
- calc_valid  out  1  operand_a/operand_b/op presented to ALU
- calc_ready  in  1  ALU accepts; transfer on edge with calc_valid && calc_ready
- display_value  out  WIDTH  value shown to the user
- entry_error  out  1  one-cycle pulse on a rejected key

## Operation
- States: S_A (entering A), S_B (entering B), S_ISSUE (handshake), S_DONE (result pending).
- Digit accept: acc ← acc*10 + digit, digit count +1. If the count is already MAX_DIGITS, the digit is dropped and entry_error pulses.
- S_A:
  - Digit: accumulate into A.
  - Operator: latch op, clear B and its count, go to S_B.
  - EQUALS: error.
  - CLEAR: A←0, count←0.
- S_B:
  - Digit: accumulate into B.
  - Operator with B count 0: replace op, no error.
  - Operator with B count > 0: error, ignored.
  - EQUALS with B count > 0: go to S_ISSUE.
  - EQUALS with B count 0: error.
  - CLEAR: A, B, op ← 0, go to S_A.
- S_ISSUE:
  - key_ready = 0 and calc_valid = 1.
  - Leaves to S_DONE on transfer.
  - Key inputs are ignored, and no error is raised.
- S_DONE:
  - Digit: A←digit, count←1, B←0, go to S_A.
  - CLEAR: go to S_A zeroed.
  - Operator / EQUALS: error.
- display_value:
  - S_A: A.
  - S_B: B if the B count > 0, else A.
  - S_ISSUE / S_DONE: B.
- The two entry_error conditions (digit overflow and an illegal key) are mutually exclusive within one key.

## Timing
- Reset values:
  - state S_A; operand_a, operand_b, op, display_value all 0.
  - calc_valid 0, entry_error 0, key_ready 1.
- All outputs are registered. An accepted key is reflected on outputs the cycle after the accepting edge.
- entry_error is high for exactly the one cycle following the offending edge.
- calc_valid rises one cycle after the EQUALS edge.
- While calc_valid is high, operand_a, operand_b and op are held stable. calc_valid stays high until a transfer edge, then falls the next cycle.
- key_ready falls together with calc_valid rising, and rises the cycle after transfer.
- calc_ready high in the same cycle calc_valid first rises: the transfer occurs on that edge, so calc_valid is high for exactly 1 cycle.
- calc_ready high while calc_valid is low: no effect.
- reset asserted mid-handshake or mid-entry: next edge forces all reset values, and any pending transfer is abandoned.
- Arithmetic: acc*10 + digit is computed at WIDTH+4 bits and truncated to WIDTH. Overflow cannot occur given the parameter constraint.

## Structure
- Package calc_pkg holds:
  - key code constants (KEY_ADD = 4'd10 … KEY_CLEAR = 4'd15)
  - op encoding (OP_ADD … OP_DIV)
  - state enum (S_A, S_B, S_ISSUE, S_DONE)
- These are shared with the ALU and keypad decoder.
- Sub-module digit_accumulator, parameterised by WIDTH and MAX_DIGITS:
  - value and digit-count registers
  - load_digit, clear and start-with-digit controls
  - full flag
- operand_entry instantiates it twice (A and B) plus the FSM and output registers.

## Test plan
- Keys 1,2,ADD,3,4,EQUALS with calc_ready=1 → single calc_valid pulse with operand_a=12, operand_b=34, op=00; display shows 1, 12, 12, 3, 34.
- Keys 9,9,9,9,9 → A=9999; the fifth digit raises entry_error for one cycle; display stays 9999.
- Keys 5,MUL,DIV,7,EQUALS with calc_ready held 0 for 6 cycles → op=11; calc_valid high 6 cycles then transfers; key_valid pulses during the wait are ignored with no entry_error.
- Key EQUALS in S_A, and EQUALS right after an operator → entry_error pulse each time; state unchanged.
- Mid-handshake reset (calc_valid=1) → next cycle all outputs 0, key_ready=1, state S_A.
- In S_DONE: key 8 → display 8 and S_A; then CLEAR → display 0; then ADD, SUB → op=01 with no error.

Source files
------------

// File: rtl/calc_pkg.sv
`default_nettype none
// ============================================================================
// Module      : calc_pkg
// Description : Key codes, ALU op encoding and entry states shared by the
//               keypad decoder, operand entry sequencer and ALU.
// Revision    : 1.0 - initial release
// ============================================================================
package calc_pkg;

    localparam logic [3:0] KEY_ADD    = 4'd10;
    localparam logic [3:0] KEY_SUB    = 4'd11;
    localparam logic [3:0] KEY_MUL    = 4'd12;
    localparam logic [3:0] KEY_DIV    = 4'd13;
    localparam logic [3:0] KEY_EQUALS = 4'd14;
    localparam logic [3:0] KEY_CLEAR  = 4'd15;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_MUL = 2'b10;
    localparam logic [1:0] OP_DIV = 2'b11;

    typedef enum logic [1:0] {
        S_A     = 2'd0,
        S_B     = 2'd1,
        S_ISSUE = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    function automatic logic is_digit(input logic [3:0] code);
        return code <= 4'd9;
    endfunction

    function automatic logic is_operator(input logic [3:0] code);
        return (code >= KEY_ADD) && (code <= KEY_DIV);
    endfunction

    // Operator keys are contiguous, so the op is the offset from KEY_ADD.
    function automatic logic [1:0] key_to_op(input logic [3:0] code);
        logic [3:0] w_diff;
        w_diff = code - KEY_ADD;
        return w_diff[1:0];
    endfunction

endpackage
`default_nettype wire

// File: rtl/digit_accumulator.sv
`default_nettype none
// ============================================================================
// Module      : digit_accumulator
// Description : Decimal entry register: value = value*10 + digit, bounded to
//               MAX_DIGITS digits. Exposes next-cycle value for registered
//               consumers.
// Revision    : 1.0 - initial release
// ============================================================================
module digit_accumulator #(
    parameter int WIDTH      = 16,
    parameter int MAX_DIGITS = 4,
    parameter int CNT_W      = $clog2(MAX_DIGITS + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [3:0]       i_digit,
    input  logic             i_load,
    input  logic             i_start,
    input  logic             i_clear,
    output logic [WIDTH-1:0] o_value,
    output logic [CNT_W-1:0] o_count,
    output logic             o_full,
    output logic [WIDTH-1:0] o_value_next,
    output logic [CNT_W-1:0] o_count_next
);
    localparam logic [WIDTH+3:0] c_TEN  = (WIDTH + 4)'(10);
    localparam logic [CNT_W-1:0] c_FULL = CNT_W'(MAX_DIGITS);
    localparam logic [CNT_W-1:0] c_ONE  = CNT_W'(1);

    logic [WIDTH-1:0] r_value;
    logic [CNT_W-1:0] r_count;
    logic [WIDTH+3:0] w_ext;

    assign w_ext = ({4'b0000, r_value} * c_TEN) + (WIDTH + 4)'(i_digit);

    always_comb begin
        o_value_next = r_value;
        o_count_next = r_count;
        if (i_clear) begin
            o_value_next = '0;
            o_count_next = '0;
        end else if (i_start) begin
            o_value_next = WIDTH'(i_digit);
            o_count_next = c_ONE;
        end else if (i_load && !o_full) begin
            o_value_next = w_ext[WIDTH-1:0];
            o_count_next = r_count + c_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_value <= '0;
            r_count <= '0;
        end else begin
            r_value <= o_value_next;
            r_count <= o_count_next;
        end
    end

    assign o_value = r_value;
    assign o_count = r_count;
    assign o_full  = (r_count == c_FULL);

endmodule
`default_nettype wire

// File: rtl/operand_entry.sv
`default_nettype none
// ============================================================================
// Module      : operand_entry
// Description : Turns decoded key codes into two decimal operands and an
//               operator, issues them to the ALU over valid/ready.
// Revision    : 1.0 - initial release
// ============================================================================
module operand_entry
    import calc_pkg::*;
#(
    parameter int WIDTH      = 16,
    parameter int MAX_DIGITS = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             key_valid,
    input  logic [3:0]       key_code,
    output logic             key_ready,
    output logic [WIDTH-1:0] operand_a,
    output logic [WIDTH-1:0] operand_b,
    output logic [1:0]       op,
    output logic             calc_valid,
    input  logic             calc_ready,
    output logic [WIDTH-1:0] display_value,
    output logic             entry_error
);
    localparam int CNT_W = $clog2(MAX_DIGITS + 1);

    state_t           r_state, w_state_next;
    logic             r_key_ready, r_calc_valid, r_entry_error;
    logic [1:0]       r_op, w_op_next;
    logic [WIDTH-1:0] r_display, w_display_next;
    logic             w_key, w_error, w_digit, w_oper;
    logic             w_a_load, w_a_start, w_a_clear, w_a_full;
    logic             w_b_load, w_b_clear, w_b_full;
    logic [WIDTH-1:0] w_a_value, w_a_value_next, w_b_value, w_b_value_next;
    logic [CNT_W-1:0] w_a_count, w_a_count_next, w_b_count, w_b_count_next;
    logic             w_unused;

    assign w_key    = key_valid && r_key_ready;
    assign w_digit  = is_digit(key_code);
    assign w_oper   = is_operator(key_code);
    assign w_unused = ^{w_a_count, w_a_count_next};

    digit_accumulator #(.WIDTH(WIDTH), .MAX_DIGITS(MAX_DIGITS)) u_acc_a (
        .clk(clk), .reset(reset), .i_digit(key_code),
        .i_load(w_a_load), .i_start(w_a_start), .i_clear(w_a_clear),
        .o_value(w_a_value), .o_count(w_a_count), .o_full(w_a_full),
        .o_value_next(w_a_value_next), .o_count_next(w_a_count_next)
    );

    digit_accumulator #(.WIDTH(WIDTH), .MAX_DIGITS(MAX_DIGITS)) u_acc_b (
        .clk(clk), .reset(reset), .i_digit(key_code),
        .i_load(w_b_load), .i_start(1'b0), .i_clear(w_b_clear),
        .o_value(w_b_value), .o_count(w_b_count), .o_full(w_b_full),
        .o_value_next(w_b_value_next), .o_count_next(w_b_count_next)
    );

    always_ff @(posedge clk) begin
        if (reset) r_state <= S_A;
        else       r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        w_op_next    = r_op;
        w_error      = 1'b0;
        w_a_load     = 1'b0;
        w_a_start    = 1'b0;
        w_a_clear    = 1'b0;
        w_b_load     = 1'b0;
        w_b_clear    = 1'b0;
        case (r_state)
            S_A: if (w_key) begin
                if (w_digit) begin
                    w_a_load = 1'b1;
                    w_error  = w_a_full;
                end else if (w_oper) begin
                    w_op_next    = key_to_op(key_code);
                    w_b_clear    = 1'b1;
                    w_state_next = S_B;
                end else if (key_code == KEY_EQUALS) begin
                    w_error = 1'b1;
                end else begin
                    w_a_clear = 1'b1;
                end
            end
            S_B: if (w_key) begin
                if (w_digit) begin
                    w_b_load = 1'b1;
                    w_error  = w_b_full;
                end else if (w_oper) begin
                    // An operator may be swapped only before B has any digits.
                    if (w_b_count == '0) w_op_next = key_to_op(key_code);
                    else                 w_error   = 1'b1;
                end else if (key_code == KEY_EQUALS) begin
                    if (w_b_count != '0) w_state_next = S_ISSUE;
                    else                 w_error      = 1'b1;
                end else begin
                    w_a_clear    = 1'b1;
                    w_b_clear    = 1'b1;
                    w_op_next    = OP_ADD;
                    w_state_next = S_A;
                end
            end
            S_ISSUE: begin
                if (r_calc_valid && calc_ready) w_state_next = S_DONE;
            end
            S_DONE: if (w_key) begin
                if (w_digit) begin
                    w_a_start    = 1'b1;
                    w_b_clear    = 1'b1;
                    w_state_next = S_A;
                end else if (key_code == KEY_CLEAR) begin
                    w_a_clear    = 1'b1;
                    w_b_clear    = 1'b1;
                    w_op_next    = OP_ADD;
                    w_state_next = S_A;
                end else begin
                    w_error = 1'b1;
                end
            end
            default: w_state_next = S_A;
        endcase
    end

    // Display is registered from next-cycle values so it tracks the key edge.
    always_comb begin
        w_display_next = w_b_value_next;
        case (w_state_next)
            S_A:     w_display_next = w_a_value_next;
            S_B:     w_display_next = (w_b_count_next != '0) ? w_b_value_next
                                                             : w_a_value_next;
            default: w_display_next = w_b_value_next;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_op          <= OP_ADD;
            r_calc_valid  <= 1'b0;
            r_key_ready   <= 1'b1;
            r_entry_error <= 1'b0;
            r_display     <= '0;
        end else begin
            r_op          <= w_op_next;
            r_calc_valid  <= (w_state_next == S_ISSUE);
            r_key_ready   <= (w_state_next != S_ISSUE);
            r_entry_error <= w_error;
            r_display     <= w_display_next;
        end
    end

    assign key_ready     = r_key_ready;
    assign calc_valid    = r_calc_valid;
    assign entry_error   = r_entry_error;
    assign op            = r_op;
    assign operand_a     = w_a_value;
    assign operand_b     = w_b_value;
    assign display_value = r_display;

endmodule
`default_nettype wire
